lcd_value_formatter: RTL and testbench



---
 rtl/lcd_fmt_pkg.sv | 13 +
 rtl/lcd_value_formatter_if.sv | 12 +
 rtl/bin2bcd_seq.sv | 43 ++++
 rtl/lcd_value_formatter.sv | 72 +++++++
 tb/tb_lcd_value_formatter.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/lcd_fmt_pkg.sv
// lcd_fmt_pkg: shared FSM states and character/frame constants for lcd_value_formatter.
// Ports: none. Macro LCD_UNIT_SUFFIX_EN lengthens the frame by the " Wh" suffix.
package lcd_fmt_pkg;
   typedef enum logic [2:0] {IDLE, CONVERT, SEND, WAIT_ACK, WAIT_DONE, NEXT} state_t;
   localparam logic [3:0] NUM_DIGITS = 4'd10;
   localparam logic [7:0] ASCII_ZERO = 8'h30, ASCII_SPACE = 8'h20, ASCII_W = 8'h57, ASCII_H = 8'h68;
   localparam logic RS_CMD = 1'b0, RS_CHAR = 1'b1;
`ifdef LCD_UNIT_SUFFIX_EN
   localparam logic [3:0] FRAME_LEN = NUM_DIGITS + 4'd4;
`else
   localparam logic [3:0] FRAME_LEN = NUM_DIGITS + 4'd1;
`endif
endpackage

// File: rtl/lcd_value_formatter_if.sv
// lcd_value_formatter_if: value/update request plus lcd driver word handshake.
// master = formatter (drives d_out, data_ready, frame_busy); slave = system/driver side.
interface lcd_value_formatter_if;
   logic [31:0] datobase;
   logic        update;
   logic        lcd_busy;
   logic [8:0]  d_out;
   logic        data_ready;
   logic        frame_busy;
   modport master (input datobase, update, lcd_busy, output d_out, data_ready, frame_busy);
   modport slave (output datobase, update, lcd_busy, input d_out, data_ready, frame_busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative 32-bit binary to 40-bit BCD (double dabble, one bit per cycle).
// Ports: clock, reset_n, i_start (loads i_bin, clears BCD), i_bin, o_bcd (held after done),
// o_done (one-cycle pulse the cycle after the 32nd iteration).
module bin2bcd_seq (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        i_start,
   input  logic [31:0] i_bin,
   output logic [39:0] o_bcd,
   output logic        o_done
);
   logic [31:0] r_sh;
   logic [4:0]  r_cnt;
   logic        r_busy, r_done;
   logic [39:0] r_bcd, w_adj;
   always_comb
      for (int i = 0; i < 10; i++)
         w_adj[4*i +: 4] = r_bcd[4*i +: 4] >= 4'd5 ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         r_sh   <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_bcd  <= '0;
      end else if (i_start) begin
         r_sh   <= i_bin;
         r_cnt  <= '0;
         r_busy <= 1'b1;
         r_done <= 1'b0;
         r_bcd  <= '0;
      end else begin
         r_done <= r_busy && r_cnt == 5'd31;
         if (r_busy) begin
            r_bcd  <= (w_adj << 1) | {39'd0, r_sh[31]};
            r_sh   <= r_sh << 1;
            r_cnt  <= r_cnt + 5'd1;
            r_busy <= r_cnt != 5'd31;
         end
      end
   assign o_bcd  = r_bcd;
   assign o_done = r_done;
endmodule

// File: rtl/lcd_value_formatter.sv
// lcd_value_formatter: formats datobase as a blanked 10-digit ASCII frame and streams it to the lcd driver.
// Ports: clock, reset_n (async active-low), bus (lcd_value_formatter_if.master).
// Macro LCD_UNIT_SUFFIX_EN appends " Wh" after the units digit (14-word frame instead of 11).
module lcd_value_formatter
   import lcd_fmt_pkg::*;
#(
   parameter logic [7:0] LINE_ADDR = 8'h80
) (
   input logic                  clock,
   input logic                  reset_n,
   lcd_value_formatter_if.master bus
);
   state_t      r_state, w_next;
   logic [3:0]  r_idx;
   logic        r_pending, w_last, w_start, w_done;
   logic [39:0] w_bcd, w_hi;
   logic [5:0]  w_sh;
   logic [8:0]  w_word;
   assign w_last  = r_idx == FRAME_LEN - 4'd1;
   // A request arriving in the final NEXT cycle counts as pending and restarts immediately.
   assign w_start = (r_state == IDLE && bus.update) ||
                    (r_state == NEXT && w_last && (r_pending || bus.update));
   bin2bcd_seq u_conv (
      .clock   (clock),
      .reset_n (reset_n),
      .i_start (w_start),
      .i_bin   (bus.datobase),
      .o_bcd   (w_bcd),
      .o_done  (w_done)
   );
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      w_next = bus.update ? CONVERT : IDLE;
         CONVERT:   w_next = w_done ? SEND : CONVERT;
         SEND:      w_next = bus.lcd_busy ? SEND : WAIT_ACK;
         WAIT_ACK:  w_next = bus.lcd_busy ? WAIT_DONE : WAIT_ACK;
         WAIT_DONE: w_next = bus.lcd_busy ? WAIT_DONE : NEXT;
         NEXT:      w_next = !w_last ? SEND : w_start ? CONVERT : IDLE;
         default:   w_next = IDLE;
      endcase
   end
   // w_hi holds the current digit and every more significant one; all zero means a leading zero.
   always_comb begin
      w_sh   = {NUM_DIGITS - r_idx, 2'b00};
      w_hi   = w_bcd >> w_sh;
      w_word = {RS_CHAR, ASCII_SPACE};
      if (r_idx == 4'd0)
         w_word = {RS_CMD, LINE_ADDR};
      else if (r_idx <= NUM_DIGITS)
         w_word = {RS_CHAR, (w_hi == '0 && r_idx != NUM_DIGITS) ? ASCII_SPACE : ASCII_ZERO + {4'h0, w_hi[3:0]}};
`ifdef LCD_UNIT_SUFFIX_EN
      else if (r_idx == NUM_DIGITS + 4'd2)
         w_word = {RS_CHAR, ASCII_W};
      else if (r_idx == NUM_DIGITS + 4'd3)
         w_word = {RS_CHAR, ASCII_H};
`endif
   end
   assign bus.d_out      = (r_state == IDLE || r_state == CONVERT) ? 9'h000 : w_word;
   assign bus.data_ready = r_state == SEND && !bus.lcd_busy;
   assign bus.frame_busy = r_state != IDLE;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_pending <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_idx     <= r_state != NEXT ? r_idx : w_last ? 4'd0 : r_idx + 4'd1;
         r_pending <= w_start ? 1'b0 : r_pending | (bus.update && r_state != IDLE);
      end
endmodule

// File: tb/tb_lcd_value_formatter.sv
// tb_lcd_value_formatter: directed frame vectors plus busy-gating, pending-update and reset sequences.
module tb_lcd_value_formatter;
`ifdef LCD_UNIT_SUFFIX_EN
   localparam int FLEN = 14;
`else
   localparam int FLEN = 11;
`endif
   typedef struct {
      logic [31:0] val;
      string       txt;
   } vec_t;
   logic       clock = 1'b0, reset_n = 1'b0;
   logic       drv_busy = 1'b0, force_busy = 1'b0;
   logic [8:0] cap[$];
   int         n_vec = 0, n_err = 0;
   vec_t       tbl[9];
   lcd_value_formatter_if bus ();
   lcd_value_formatter dut (.clock(clock), .reset_n(reset_n), .bus(bus));
   assign bus.lcd_busy = drv_busy | force_busy;
   always #5 clock = ~clock;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] sfx(int k);
      return k == 11 ? 9'h120 : k == 12 ? 9'h157 : 9'h168;
   endfunction

   task automatic check_frame(string name, string txt, int base);
      logic [8:0] e;
      for (int k = 0; k < FLEN; k++) begin
         e = k == 0 ? 9'h080 : k <= 10 ? {1'b1, 8'(txt[k-1])} : sfx(k);
         chk($sformatf("%s_w%0d", name, k), 32'(base + k < cap.size() ? cap[base+k] : 9'h1ff), 32'(e));
      end
   endtask

   task automatic pulse_update(logic [31:0] v);
      @(negedge clock);
      bus.datobase = v;
      bus.update = 1'b1;
      @(negedge clock);
      bus.update = 1'b0;
   endtask

   task automatic wait_idle(string name);
      int n = 0;
      while (bus.frame_busy && n < 5000) begin
         @(negedge clock);
         n++;
      end
      chk({name, "_done_in_time"}, 32'(n < 5000), 32'd1);
   endtask

   task automatic wait_words(int cnt);
      int n = 0;
      while (cap.size() < cnt && n < 2000) begin
         @(negedge clock);
         n++;
      end
      chk("words_in_time", 32'(n < 2000), 32'd1);
   endtask

   // Driver model: takes a strobed word, goes busy the next cycle for a few cycles, then releases.
   initial forever begin
      @(negedge clock);
      if (bus.data_ready) begin
         cap.push_back(bus.d_out);
         @(posedge clock);
         #1 drv_busy = 1'b1;
         repeat (3) @(posedge clock);
         #1;
         if (reset_n) chk("d_out_hold", 32'(bus.d_out), 32'(cap[$]));
         drv_busy = 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit hit, expected finish before 2 ms");
      $fatal(1);
   end

   initial begin
      int n, n0;
      bus.datobase = '0;
      bus.update = 1'b0;
      tbl[0] = '{32'd0,          "         0"};
      tbl[1] = '{32'hFFFFFFFF,   "4294967295"};
      tbl[2] = '{32'd1234,       "      1234"};
      tbl[3] = '{32'd42,         "        42"};
      tbl[4] = '{32'd10,         "        10"};
      tbl[5] = '{32'd100000,     "    100000"};
      tbl[6] = '{32'd1000000000, "1000000000"};
      tbl[7] = '{32'd999999999,  " 999999999"};
      tbl[8] = '{32'd7,          "         7"};
      #1;
      chk("rst_d_out", 32'(bus.d_out), 32'h0);
      chk("rst_data_ready", 32'(bus.data_ready), 32'h0);
      chk("rst_frame_busy", 32'(bus.frame_busy), 32'h0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      cap.delete();
      pulse_update(tbl[0].val);
      chk("busy_after_update", 32'(bus.frame_busy), 32'd1);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.data_ready && n < 100);
      chk("first_strobe_latency", 32'(n), 32'd33);
      wait_idle("v0");
      chk("v0_strobes", 32'(cap.size()), 32'(FLEN));
      check_frame("v0", tbl[0].txt, 0);
      for (int i = 1; i < 9; i++) begin
         cap.delete();
         pulse_update(tbl[i].val);
         wait_idle($sformatf("v%0d", i));
         chk($sformatf("v%0d_strobes", i), 32'(cap.size()), 32'(FLEN));
         check_frame($sformatf("v%0d", i), tbl[i].txt, 0);
      end
      cap.delete();
      force_busy = 1'b1;
      pulse_update(32'd1234);
      repeat (10000) @(negedge clock);
      chk("gated_strobes", 32'(cap.size()), 32'd0);
      @(posedge clock);
      #1 force_busy = 1'b0;
      @(negedge clock);
      chk("strobe_after_release", 32'(bus.data_ready), 32'd1);
      wait_idle("gate");
      check_frame("gate", "      1234", 0);
      cap.delete();
      pulse_update(32'd5);
      wait_words(3);
      pulse_update(32'd77);
      repeat (20) @(negedge clock);
      pulse_update(32'd77);
      wait_idle("pend");
      chk("pend_strobes", 32'(cap.size()), 32'(2 * FLEN));
      check_frame("pend1", "         5", 0);
      check_frame("pend2", "        77", FLEN);
      repeat (300) @(negedge clock);
      chk("pend_no_third", 32'(cap.size()), 32'(2 * FLEN));
      cap.delete();
      pulse_update(32'hFFFFFFFF);
      wait_words(4);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_d_out", 32'(bus.d_out), 32'h0);
      chk("mid_rst_data_ready", 32'(bus.data_ready), 32'h0);
      chk("mid_rst_frame_busy", 32'(bus.frame_busy), 32'h0);
      repeat (10) @(negedge clock);
      reset_n = 1'b1;
      n0 = cap.size();
      repeat (300) @(negedge clock);
      chk("no_strobe_after_reset", 32'(cap.size()), 32'(n0));
      chk("idle_after_reset", 32'(bus.frame_busy), 32'h0);
      cap.delete();
      pulse_update(32'd42);
      wait_idle("recover");
      chk("recover_strobes", 32'(cap.size()), 32'(FLEN));
      check_frame("recover", "        42", 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
